shift_reg_feeder: RTL and testbench

Parallel-to-serial feeder that sits directly upstream of the 4-bit shift register. It accepts a DATA_W-bit word over a valid/ready handshake and drives the register's din/en/dir inputs one bit per programmable bit period. Bit order follows the captured direction, so the register ends each frame holding the word's last-inserted nibble in natural order. A one-cycle done pulse marks frame completion.

---
 rtl/shift_reg_feeder.sv | 140 ++++++++++++++
 tb/tb_shift_reg_feeder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_reg_feeder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | shift_reg_feeder: parallel word to serial din/en/dir for a shift register |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module shift_reg_feeder #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_dir,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DIV_W-1:0]  div,
  input  logic              abort,
  output logic              sr_din,
  output logic              sr_en,
  output logic              sr_dir,
  output logic              busy,
  output logic              done
);

  localparam int                CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0]  C_LAST   = CNT_W'(DATA_W);
  localparam logic [1:0]        ST_IDLE  = 2'd0;
  localparam logic [1:0]        ST_SHIFT = 2'd1;
  localparam logic [1:0]        ST_DONE  = 2'd2;

  logic [1:0]        state_q,  state_d;
  logic [DATA_W-1:0] word_q,   word_d;
  logic [DIV_W-1:0]  div_q,    div_d;
  logic [DIV_W-1:0]  tick_q,   tick_d;
  logic [CNT_W-1:0]  bitcnt_q, bitcnt_d;
  logic              dir_q,    dir_d;
  logic              din_q,    din_d;
  logic              en_q,     en_d;
  logic              busy_q,   busy_d;
  logic              done_q,   done_d;
  logic              ready_q,  ready_d;

  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    div_d    = div_q;
    tick_d   = tick_q;
    bitcnt_d = bitcnt_q;
    dir_d    = dir_q;
    din_d    = din_q;
    en_d     = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    ready_d  = ready_q;

    case (state_q)
      ST_IDLE: begin
        // abort outranks a simultaneous handshake
        if (!abort && s_valid && ready_q) begin
          word_d   = s_data;
          dir_d    = s_dir;
          div_d    = div;
          tick_d   = div;
          bitcnt_d = '0;
          state_d  = ST_SHIFT;
          ready_d  = 1'b0;
          busy_d   = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          din_d   = 1'b0;
        end else if (bitcnt_q == C_LAST) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else if (tick_q == '0) begin
          en_d     = 1'b1;
          din_d    = dir_q ? word_q[0] : word_q[DATA_W-1];
          word_d   = dir_q ? {1'b0, word_q[DATA_W-1:1]} : {word_q[DATA_W-2:0], 1'b0};
          bitcnt_d = bitcnt_q + CNT_W'(1);
          tick_d   = div_q;
        end else begin
          tick_d = tick_q - DIV_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        din_d   = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        din_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      word_q   <= '0;
      div_q    <= '0;
      tick_q   <= '0;
      bitcnt_q <= '0;
      dir_q    <= 1'b0;
      din_q    <= 1'b0;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      div_q    <= div_d;
      tick_q   <= tick_d;
      bitcnt_q <= bitcnt_d;
      dir_q    <= dir_d;
      din_q    <= din_d;
      en_q     <= en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
    end
  end

  assign s_ready = ready_q;
  assign sr_din  = din_q;
  assign sr_en   = en_q;
  assign sr_dir  = dir_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_reg_feeder.sv
`default_nettype none
// Directed testbench for shift_reg_feeder with a 4-bit downstream register model.
module tb_shift_reg_feeder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] s_data;
  logic       s_dir;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] div;
  logic       abort;
  logic       sr_din, sr_en, sr_dir, busy, done;
  logic [3:0] q_m;
  int         n_chk = 0;
  int         n_fail = 0;

  shift_reg_feeder #(.DATA_W(8), .DIV_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_dir(s_dir), .s_valid(s_valid),
    .s_ready(s_ready), .div(div), .abort(abort), .sr_din(sr_din), .sr_en(sr_en),
    .sr_dir(sr_dir), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // downstream 4-bit shift register
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_m <= 4'h0;
    else if (sr_en) q_m <= sr_dir ? {sr_din, q_m[3:1]} : {q_m[2:0], sr_din};
  end

  // Present one word while idle; returns at the negedge right after the accept edge.
  task automatic send(input logic [7:0] d, input logic dir, input logic [7:0] dv);
    @(negedge clk);
    s_data = d; s_dir = dir; div = dv; s_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; s_data = 8'h00; s_dir = 1'b0; s_valid = 1'b0; div = 8'h00; abort = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({s_ready, sr_din, sr_en, sr_dir, busy, done} !== 6'b100000) begin
      n_fail++;
      $display("FAIL reset_values got=%b exp=100000", {s_ready, sr_din, sr_en, sr_dir, busy, done});
    end
  endtask

  task automatic test_reset_midframe;
    logic [7:0] w;
    w = 8'hB2;
    send(w, 1'b0, 8'd0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      n_chk++;
      if (sr_en !== 1'b1 || sr_din !== w[8-k]) begin
        n_fail++;
        $display("FAIL pre_reset_strobe k=%0d got en=%b din=%b exp en=1 din=%b", k, sr_en, sr_din, w[8-k]);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({sr_en, sr_din, busy, done, s_ready} !== 5'b00001) begin
      n_fail++;
      $display("FAIL async_reset got en,din,busy,done,ready=%b exp=00001", {sr_en, sr_din, busy, done, s_ready});
    end
    repeat (2) begin
      @(negedge clk);
      n_chk++;
      if (done !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_no_done got=%b exp=0", done);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++;
    if (s_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_after_reset got ready=%b busy=%b exp 1 0", s_ready, busy);
    end
    send(w, 1'b0, 8'd0);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      n_chk++;
      if (sr_en !== (k <= 8) || done !== (k == 9) || s_ready !== (k == 10) ||
          (k <= 8 && sr_din !== w[8-k])) begin
        n_fail++;
        $display("FAIL left_frame k=%0d got en=%b din=%b done=%b ready=%b", k, sr_en, sr_din, done, s_ready);
      end
    end
    n_chk++;
    if (q_m !== 4'h2) begin
      n_fail++;
      $display("FAIL left_q got=%h exp=2", q_m);
    end
  endtask

  task automatic test_right_shift;
    logic [7:0] w;
    w = 8'hB2;
    send(w, 1'b1, 8'd0);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      n_chk++;
      if (sr_dir !== 1'b1 || sr_en !== (k <= 8) || done !== (k == 9) ||
          (k <= 8 && sr_din !== w[k-1])) begin
        n_fail++;
        $display("FAIL right_frame k=%0d got dir=%b en=%b din=%b done=%b exp din=%b",
                 k, sr_dir, sr_en, sr_din, done, w[(k-1)%8]);
      end
    end
    n_chk++;
    if (q_m !== 4'hB) begin
      n_fail++;
      $display("FAIL right_q got=%h exp=b", q_m);
    end
  endtask

  task automatic test_bit_period;
    logic [7:0] w;
    w = 8'h81;
    send(w, 1'b0, 8'd3);
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      n_chk++;
      if (sr_en !== (k % 4 == 0 && k <= 32) || done !== (k == 33) || busy !== (k <= 33) ||
          s_ready !== (k == 34) || (k % 4 == 0 && k <= 32 && sr_din !== w[8-k/4])) begin
        n_fail++;
        $display("FAIL period_frame k=%0d got en=%b din=%b done=%b busy=%b ready=%b",
                 k, sr_en, sr_din, done, busy, s_ready);
      end
    end
  endtask

  task automatic test_abort;
    logic [7:0] w;
    int strobes;
    strobes = 0;
    send(8'hFF, 1'b0, 8'd0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (sr_en === 1'b1) strobes++;
      n_chk++;
      if (sr_en !== (k <= 3) || done !== 1'b0 ||
          (k >= 4 && (s_ready !== 1'b1 || busy !== 1'b0 || sr_din !== 1'b0))) begin
        n_fail++;
        $display("FAIL abort_frame k=%0d got en=%b din=%b done=%b ready=%b busy=%b",
                 k, sr_en, sr_din, done, s_ready, busy);
      end
      if (k == 3) abort = 1'b1;
      if (k == 4) abort = 1'b0;
    end
    n_chk++;
    if (strobes != 3) begin
      n_fail++;
      $display("FAIL abort_strobes got=%0d exp=3", strobes);
    end
    // abort together with s_valid in idle: nothing accepted
    w = 8'h0F;
    s_data = w; s_dir = 1'b0; div = 8'd0; s_valid = 1'b1; abort = 1'b1;
    @(negedge clk);
    n_chk++;
    if (s_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_vs_valid got ready=%b busy=%b exp 1 0", s_ready, busy);
    end
    abort = 1'b0;
    @(negedge clk);
    s_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      n_chk++;
      if (sr_en !== (k <= 8) || done !== (k == 9) || (k <= 8 && sr_din !== w[8-k])) begin
        n_fail++;
        $display("FAIL post_abort_frame k=%0d got en=%b din=%b done=%b", k, sr_en, sr_din, done);
      end
    end
    n_chk++;
    if (q_m !== 4'hF) begin
      n_fail++;
      $display("FAIL post_abort_q got=%h exp=f", q_m);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] w;
    int m, strobes, accepts;
    strobes = 0;
    accepts = 0;
    @(negedge clk);
    s_data = 8'h5A; s_dir = 1'b0; div = 8'd1; s_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_data = 8'hC3;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k <= 18) begin m = k; w = 8'h5A; end
      else begin m = k - 19; w = 8'hC3; end
      if (sr_en === 1'b1) strobes++;
      if (s_valid && s_ready) accepts++;
      n_chk++;
      if (sr_en !== (m >= 2 && m <= 16 && m % 2 == 0) || done !== (m == 17) ||
          s_ready !== (m >= 18) ||
          (m >= 2 && m <= 16 && m % 2 == 0 && sr_din !== w[8-m/2])) begin
        n_fail++;
        $display("FAIL b2b_frame k=%0d got en=%b din=%b done=%b ready=%b", k, sr_en, sr_din, done, s_ready);
      end
      if (k == 3)  div = 8'd7;
      if (k == 10) div = 8'd1;
      if (k == 19) s_valid = 1'b0;
    end
    n_chk++;
    if (strobes != 16 || accepts != 1) begin
      n_fail++;
      $display("FAIL b2b_counts got strobes=%0d accepts=%0d exp 16 1", strobes, accepts);
    end
    n_chk++;
    if (q_m !== 4'h3) begin
      n_fail++;
      $display("FAIL b2b_q got=%h exp=3", q_m);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_reset_midframe();
    test_right_shift();
    test_bit_period();
    test_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
